wb_burst_sram_responder: RTL and testbench
==========================================

# wb_burst_sram_responder

Wishbone responder terminating the core's memory bus: single and 4/8-beat burst reads, byte-masked single writes, error signalling. Serves a 16-bit on-chip word array behind the core-side arbiter output (cyc/stb/we/adr/sel/dat/4_burst/8_burst), completing every cycle the core-side caches initiate.

## Interface
- `ADDR_W`, 24: Wishbone word-address width.
- `DEPTH_LOG2`, 10: log2 of array depth in 16-bit words.
- `BASE`, 0: value required on `wb_adr[ADDR_W-1:DEPTH_LOG2]` (used only with `WB_RESP_ERR_EN`).

- `i_clk` in 1: clock; all state on rising edge.
- `i_rst_n` in 1: reset, synchronous, active-low.
- `wb_cyc` in 1: bus cycle active.
- `wb_stb` in 1: request strobe.
- `wb_we` in 1: 1 = write.
- `wb_adr` in ADDR_W: word address, sampled only in IDLE.
- `wb_i_dat` in 16: write data from initiator.
- `wb_sel` in 2: byte enables; [1] = bits 15:8, [0] = bits 7:0.
- `wb_4_burst` in 1: request is 4-beat read burst.
- `wb_8_burst` in 1: request is 8-beat read burst; wins if both set.
- `wb_o_dat` out 16: read data, valid when `wb_ack`.
- `wb_ack` out 1: beat complete.
- `wb_err` out 1: request terminated with error.
- `wb_rty` out 1: constant 0.

## Operation
- States: IDLE, ACK, BURST.
- IDLE: request = `wb_cyc & wb_stb`, sampled at edge. Latch adr, we, sel, burst length L (8, 4, or 1).
- Error check first (see Configuration); also burst with `wb_we`=1 is always an error. Error -> `wb_err`=1 for one cycle, no array access, go ACK.
- Single write: bytes with `wb_sel` bit set written at the sampling edge; `wb_sel`=0 writes nothing but still acks. -> ACK with `wb_ack`=1.
- Single read: array word driven on `wb_o_dat`, `wb_ack`=1 next cycle. -> ACK.
- ACK: always returns to IDLE next edge; `wb_stb` seen in ACK is never a new request (initiator drops stb after seeing ack). `wb_ack`/`wb_err` cleared.
- Burst read: -> BURST, 3-bit beat counter from 0. Beat i returns word at `{adr[DEPTH_LOG2-1:log2 L], (adr[log2 L-1:0] + i) mod L}` — wraps inside the aligned L-word block, never crosses it. `wb_ack`=1 on L consecutive cycles; after beat L-1 -> IDLE (no ACK state; `wb_ack` low next cycle).
- Abort: `wb_cyc`=0 sampled in BURST -> IDLE, `wb_ack` low next cycle, remaining beats dropped. `wb_stb` low in BURST with `wb_cyc` high pauses beats (counter holds, `wb_ack`=0) until stb returns.
- `wb_o_dat` holds last value when `wb_ack`=0 (no zeroing required, but must be stable).
- Array contents not reset.

## Timing
- Reset (`i_rst_n`=0 at edge): state IDLE, counter 0, `wb_ack`=0, `wb_err`=0, `wb_o_dat`=0, `wb_rty`=0 on the next cycle; in-flight burst or write ack abandoned (a write already committed at its sampling edge stays).
- Request sampled at edge N -> `wb_ack`/`wb_err` high in cycle N+1 (registered outputs, no combinational path from inputs).
- Single access throughput: one per 2 cycles (IDLE, ACK).
- Burst: acks cycles N+1..N+L uninterrupted if stb held; new request earliest at edge N+L+1.
- Write then read same word: read sampled at edge N+2 returns written data.

## Configuration
- `WB_RESP_ERR_EN` defined: request with `wb_adr[ADDR_W-1:DEPTH_LOG2]` != `BASE` -> `wb_err` one cycle, no access, no ack.
- Undefined: upper address bits ignored; array aliases across whole space; `wb_err` only for write bursts.

## Test plan
- Reset: hold `i_rst_n`=0 two cycles during 8-burst -> all outputs 0 next cycle, state IDLE, next single read acks normally.
- Write 0xA55A to word 0x010 sel=2'b11, then sel=2'b01 data 0x00FF, read 0x010 -> ack one cycle after stb sampled, data 0xA5FF; ack low in following cycle despite stb high.
- 4-burst read start 0x006 after filling words 0x004-0x007 with 4..7 -> 4 consecutive acks, data 6,7,4,5.
- 8-burst from 0x000, drop `wb_cyc` after third ack -> exactly 3 acks, IDLE, next request served.
- Both burst flags set with we=1 -> single `wb_err`, no ack, array unchanged.
- With `WB_RESP_ERR_EN`, BASE=0, read adr 0x000400 -> `wb_err`=1 one cycle; without macro same request acks with word 0x000 contents.

Source files
------------

// File: rtl/wb_burst_sram_responder.sv
// wb_burst_sram_responder
//   Wishbone responder backed by a 2**DEPTH_LOG2 x 16-bit on-chip word array.
//   Serves single reads, byte-masked single writes and 4/8-beat wrapping read
//   bursts. Burst writes are always rejected with wb_err.
//
// Optional feature macro: WB_RESP_ERR_EN
//   Defined   : a request whose wb_adr[ADDR_W-1:DEPTH_LOG2] differs from BASE is
//               terminated with wb_err (no access, no ack).
//   Undefined : upper address bits are ignored and the array aliases across
//               the whole address space.
//
// Handshake: a request is wb_cyc & wb_stb sampled at a rising edge while IDLE.
//   wb_ack / wb_err are registered and assert in the following cycle. A burst
//   beat completes at an edge where wb_ack and wb_stb are both high; wb_stb low
//   pauses the burst and wb_cyc low abandons it.
//
// Ports:
//   i_clk, i_rst_n          clock, synchronous active-low reset
//   wb_cyc, wb_stb, wb_we   bus cycle, strobe, write enable
//   wb_adr [ADDR_W-1:0]     word address (sampled only in IDLE)
//   wb_i_dat [15:0]         write data
//   wb_sel [1:0]            byte enables ([1] = bits 15:8, [0] = bits 7:0)
//   wb_4_burst, wb_8_burst  burst length request (8 wins)
//   wb_o_dat [15:0]         read data, valid with wb_ack, otherwise held
//   wb_ack, wb_err, wb_rty  terminations (wb_rty tied low)
//   dbg_state [1:0]         current FSM state (0 IDLE, 1 ACK, 2 BURST)

module wb_burst_sram_responder #(
  parameter int ADDR_W     = 24,
  parameter int DEPTH_LOG2 = 10,
  parameter int BASE       = 0
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              wb_cyc,
  input  logic              wb_stb,
  input  logic              wb_we,
  input  logic [ADDR_W-1:0] wb_adr,
  input  logic [15:0]       wb_i_dat,
  input  logic [1:0]        wb_sel,
  input  logic              wb_4_burst,
  input  logic              wb_8_burst,
  output logic [15:0]       wb_o_dat,
  output logic              wb_ack,
  output logic              wb_err,
  output logic              wb_rty,
  output logic [1:0]        dbg_state
);

  localparam int UPPER_W = ADDR_W - DEPTH_LOG2;
  localparam logic [UPPER_W-1:0] BASE_BITS = UPPER_W'(BASE);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACK   = 2'd1,
    ST_BURST = 2'd2
  } state_t;

  logic [15:0] mem [2**DEPTH_LOG2];

  state_t                state_q, state_d;
  logic [2:0]            beat_q, beat_d;
  logic [2:0]            len_m1_q, len_m1_d;
  logic [DEPTH_LOG2-1:0] adr_q, adr_d;
  logic                  ack_q, ack_d;
  logic                  err_q, err_d;
  logic [15:0]           dat_q;

  logic                  rd_en;
  logic [DEPTH_LOG2-1:0] rd_addr;
  logic                  wr_en;

  logic                  req;
  logic                  is_burst;
  logic [2:0]            req_len_m1;
  logic                  addr_err;
  logic [DEPTH_LOG2-1:0] adr_lo;

  assign req        = wb_cyc & wb_stb;
  assign is_burst   = wb_4_burst | wb_8_burst;
  assign req_len_m1 = wb_8_burst ? 3'd7 : (wb_4_burst ? 3'd3 : 3'd0);
  assign adr_lo     = wb_adr[DEPTH_LOG2-1:0];

`ifdef WB_RESP_ERR_EN
  assign addr_err = (wb_adr[ADDR_W-1:DEPTH_LOG2] != BASE_BITS);
`else
  logic unused_upper;
  assign addr_err     = 1'b0;
  assign unused_upper = ^{wb_adr[ADDR_W-1:DEPTH_LOG2], BASE_BITS};
`endif

  // Beat address: the low log2(L) bits advance modulo L, the rest stay fixed,
  // so the burst wraps inside its aligned L-word block.
  function automatic logic [DEPTH_LOG2-1:0] burst_addr(
    input logic [DEPTH_LOG2-1:0] start,
    input logic [2:0]            len_m1,
    input logic [2:0]            beat
  );
    logic [DEPTH_LOG2-1:0] mask;
    mask = DEPTH_LOG2'(len_m1);
    return (start & ~mask) | ((start + DEPTH_LOG2'(beat)) & mask);
  endfunction

  always_comb begin
    state_d  = state_q;
    beat_d   = beat_q;
    len_m1_d = len_m1_q;
    adr_d    = adr_q;
    ack_d    = 1'b0;
    err_d    = 1'b0;
    rd_en    = 1'b0;
    rd_addr  = burst_addr(adr_q, len_m1_q, beat_q);
    wr_en    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req) begin
          adr_d    = adr_lo;
          len_m1_d = req_len_m1;
          beat_d   = 3'd0;
          if (addr_err || (is_burst && wb_we)) begin
            err_d   = 1'b1;
            state_d = ST_ACK;
          end else if (is_burst) begin
            rd_en   = 1'b1;
            rd_addr = adr_lo;
            ack_d   = 1'b1;
            state_d = ST_BURST;
          end else if (wb_we) begin
            wr_en   = 1'b1;
            ack_d   = 1'b1;
            state_d = ST_ACK;
          end else begin
            rd_en   = 1'b1;
            rd_addr = adr_lo;
            ack_d   = 1'b1;
            state_d = ST_ACK;
          end
        end
      end
      ST_ACK: begin
        state_d = ST_IDLE;
      end
      ST_BURST: begin
        if (!wb_cyc) begin
          state_d = ST_IDLE;
        end else if (wb_stb) begin
          if (ack_q) begin
            // Current beat taken by the initiator.
            if (beat_q == len_m1_q) begin
              state_d = ST_IDLE;
            end else begin
              beat_d  = beat_q + 3'd1;
              rd_en   = 1'b1;
              rd_addr = burst_addr(adr_q, len_m1_q, beat_q + 3'd1);
              ack_d   = 1'b1;
            end
          end else begin
            // Resuming after a pause: re-present the beat not yet taken.
            rd_en = 1'b1;
            ack_d = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q  <= ST_IDLE;
      beat_q   <= 3'd0;
      len_m1_q <= 3'd0;
      adr_q    <= '0;
      ack_q    <= 1'b0;
      err_q    <= 1'b0;
      dat_q    <= 16'h0000;
    end else begin
      state_q  <= state_d;
      beat_q   <= beat_d;
      len_m1_q <= len_m1_d;
      adr_q    <= adr_d;
      ack_q    <= ack_d;
      err_q    <= err_d;
      if (rd_en) dat_q <= mem[rd_addr];
    end
  end

  // Array is not reset; writes are suppressed while reset is asserted.
  always_ff @(posedge i_clk) begin
    if (wr_en && i_rst_n) begin
      if (wb_sel[0]) mem[adr_lo][7:0]  <= wb_i_dat[7:0];
      if (wb_sel[1]) mem[adr_lo][15:8] <= wb_i_dat[15:8];
    end
  end

  assign wb_o_dat  = dat_q;
  assign wb_ack    = ack_q;
  assign wb_err    = err_q;
  assign wb_rty    = 1'b0;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_wb_burst_sram_responder.sv
module tb_wb_burst_sram_responder;

  localparam int ADDR_W     = 24;
  localparam int DEPTH_LOG2 = 10;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic              cyc, stb, we, b4, b8;
  logic [ADDR_W-1:0] adr;
  logic [15:0]       dat_i;
  logic [1:0]        sel;
  logic [15:0]       dat_o;
  logic              ack, err, rty;
  logic [1:0]        state;

  int checks = 0;
  int failures = 0;

  wb_burst_sram_responder #(.ADDR_W(ADDR_W), .DEPTH_LOG2(DEPTH_LOG2), .BASE(0)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .wb_cyc(cyc), .wb_stb(stb), .wb_we(we), .wb_adr(adr),
    .wb_i_dat(dat_i), .wb_sel(sel), .wb_4_burst(b4), .wb_8_burst(b8),
    .wb_o_dat(dat_o), .wb_ack(ack), .wb_err(err), .wb_rty(rty),
    .dbg_state(state)
  );

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_bus();
    cyc = 1'b0; stb = 1'b0; we = 1'b0; b4 = 1'b0; b8 = 1'b0;
    sel = 2'b00; dat_i = 16'h0000; adr = '0;
  endtask

  // Single write; returns ack/err seen in the cycle after sampling.
  task automatic do_write(input logic [ADDR_W-1:0] a, input logic [15:0] d,
                          input logic [1:0] s, output logic ack_seen);
    cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = a; dat_i = d; sel = s;
    tick();
    ack_seen = ack;
    idle_bus();
    tick();
  endtask

  task automatic do_read(input logic [ADDR_W-1:0] a, output logic ack_seen,
                         output logic err_seen, output logic [15:0] d);
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = a; sel = 2'b11;
    tick();
    ack_seen = ack; err_seen = err; d = dat_o;
    idle_bus();
    tick();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    idle_bus();
    tick(); tick();
    checks++; if (ack !== 1'b0) begin failures++; $display("FAIL reset_ack got=%b exp=0", ack); end
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", err); end
    checks++; if (rty !== 1'b0) begin failures++; $display("FAIL reset_rty got=%b exp=0", rty); end
    checks++; if (dat_o !== 16'h0000) begin failures++; $display("FAIL reset_dat got=%h exp=0000", dat_o); end
    checks++; if (state !== 2'd0) begin failures++; $display("FAIL reset_state got=%0d exp=0", state); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_fill();
    logic a_s;
    logic [15:0] vals [8];
    vals = '{16'h1000, 16'h1001, 16'h1002, 16'h1003, 16'h0004, 16'h0005, 16'h0006, 16'h0007};
    for (int i = 0; i < 8; i++) begin
      do_write(ADDR_W'(i), vals[i], 2'b11, a_s);
      checks++; if (a_s !== 1'b1) begin failures++; $display("FAIL fill_ack[%0d] got=%b exp=1", i, a_s); end
    end
  endtask

  task automatic test_byte_write();
    logic a_s, e_s;
    logic [15:0] d;
    do_write(24'h000010, 16'hA55A, 2'b11, a_s);
    checks++; if (a_s !== 1'b1) begin failures++; $display("FAIL bw_ack_11 got=%b exp=1", a_s); end
    do_write(24'h000010, 16'h00FF, 2'b01, a_s);
    checks++; if (a_s !== 1'b1) begin failures++; $display("FAIL bw_ack_01 got=%b exp=1", a_s); end
    do_write(24'h000010, 16'hFFFF, 2'b00, a_s);
    checks++; if (a_s !== 1'b1) begin failures++; $display("FAIL bw_ack_00 got=%b exp=1", a_s); end
    // Read with stb held through the ACK cycle.
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 24'h000010; sel = 2'b11;
    tick();
    checks++; if (ack !== 1'b1) begin failures++; $display("FAIL bw_read_ack got=%b exp=1", ack); end
    checks++; if (dat_o !== 16'hA5FF) begin failures++; $display("FAIL bw_read_dat got=%h exp=a5ff", dat_o); end
    tick();
    checks++; if (ack !== 1'b0) begin failures++; $display("FAIL bw_ack_drop got=%b exp=0", ack); end
    checks++; if (dat_o !== 16'hA5FF) begin failures++; $display("FAIL bw_dat_hold got=%h exp=a5ff", dat_o); end
    idle_bus();
    tick();
    // Upper byte only.
    do_write(24'h000011, 16'h1234, 2'b11, a_s);
    do_write(24'h000011, 16'hAB00, 2'b10, a_s);
    do_read(24'h000011, a_s, e_s, d);
    checks++; if (d !== 16'hAB34) begin failures++; $display("FAIL bw_sel10_dat got=%h exp=ab34", d); end
  endtask

  task automatic test_burst4();
    logic [15:0] exp_q[$];
    exp_q = '{16'h0006, 16'h0007, 16'h0004, 16'h0005};
    cyc = 1'b1; stb = 1'b1; we = 1'b0; b4 = 1'b1; adr = 24'h000006;
    tick();
    b4 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++; if (ack !== 1'b1) begin failures++; $display("FAIL b4_ack[%0d] got=%b exp=1", i, ack); end
      checks++; if (dat_o !== exp_q[i]) begin failures++; $display("FAIL b4_dat[%0d] got=%h exp=%h", i, dat_o, exp_q[i]); end
      tick();
    end
    idle_bus();
    checks++; if (ack !== 1'b0) begin failures++; $display("FAIL b4_end_ack got=%b exp=0", ack); end
    checks++; if (state !== 2'd0) begin failures++; $display("FAIL b4_end_state got=%0d exp=0", state); end
    tick();
  endtask

  task automatic test_burst8_wrap();
    logic [15:0] exp_q[$];
    exp_q = '{16'h1003, 16'h0004, 16'h0005, 16'h0006, 16'h0007, 16'h1000, 16'h1001, 16'h1002};
    // Both flags: 8 wins.
    cyc = 1'b1; stb = 1'b1; we = 1'b0; b4 = 1'b1; b8 = 1'b1; adr = 24'h000003;
    tick();
    b4 = 1'b0; b8 = 1'b0;
    for (int i = 0; i < 8; i++) begin
      checks++; if (ack !== 1'b1) begin failures++; $display("FAIL b8_ack[%0d] got=%b exp=1", i, ack); end
      checks++; if (dat_o !== exp_q[i]) begin failures++; $display("FAIL b8_dat[%0d] got=%h exp=%h", i, dat_o, exp_q[i]); end
      tick();
    end
    idle_bus();
    checks++; if (ack !== 1'b0) begin failures++; $display("FAIL b8_end_ack got=%b exp=0", ack); end
    tick();
  endtask

  task automatic test_burst_abort();
    logic [15:0] exp_q[$];
    logic a_s, e_s;
    logic [15:0] d;
    int ack_count;
    exp_q = '{16'h1000, 16'h1001, 16'h1002};
    ack_count = 0;
    cyc = 1'b1; stb = 1'b1; we = 1'b0; b8 = 1'b1; adr = 24'h000000;
    tick();
    b8 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (ack === 1'b1) ack_count++;
      checks++; if (dat_o !== exp_q[i]) begin failures++; $display("FAIL abort_dat[%0d] got=%h exp=%h", i, dat_o, exp_q[i]); end
      if (i == 2) idle_bus();
      tick();
    end
    for (int i = 0; i < 4; i++) begin
      if (ack === 1'b1) ack_count++;
      tick();
    end
    checks++; if (ack_count !== 3) begin failures++; $display("FAIL abort_ack_count got=%0d exp=3", ack_count); end
    checks++; if (state !== 2'd0) begin failures++; $display("FAIL abort_state got=%0d exp=0", state); end
    do_read(24'h000010, a_s, e_s, d);
    checks++; if (a_s !== 1'b1 || d !== 16'hA5FF) begin failures++; $display("FAIL abort_next ack=%b dat=%h exp ack=1 dat=a5ff", a_s, d); end
  endtask

  task automatic test_write_burst_err();
    logic a_s, e_s;
    logic [15:0] d;
    cyc = 1'b1; stb = 1'b1; we = 1'b1; b4 = 1'b1; b8 = 1'b1; adr = 24'h000005;
    dat_i = 16'hBEEF; sel = 2'b11;
    tick();
    checks++; if (err !== 1'b1) begin failures++; $display("FAIL wberr_err got=%b exp=1", err); end
    checks++; if (ack !== 1'b0) begin failures++; $display("FAIL wberr_ack got=%b exp=0", ack); end
    idle_bus();
    tick();
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL wberr_err_drop got=%b exp=0", err); end
    do_read(24'h000005, a_s, e_s, d);
    checks++; if (d !== 16'h0005) begin failures++; $display("FAIL wberr_array got=%h exp=0005", d); end
  endtask

  task automatic test_addr_err();
    logic a_s, e_s;
    logic [15:0] d;
    do_read(24'h000400, a_s, e_s, d);
`ifdef WB_RESP_ERR_EN
    checks++; if (e_s !== 1'b1 || a_s !== 1'b0) begin failures++; $display("FAIL addr_err err=%b ack=%b exp err=1 ack=0", e_s, a_s); end
`else
    checks++; if (a_s !== 1'b1 || e_s !== 1'b0 || d !== 16'h1000) begin failures++; $display("FAIL addr_alias ack=%b err=%b dat=%h exp ack=1 err=0 dat=1000", a_s, e_s, d); end
`endif
  endtask

  task automatic test_back_to_back();
    cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 24'h000020; dat_i = 16'h5A5A; sel = 2'b11;
    tick();
    checks++; if (ack !== 1'b1) begin failures++; $display("FAIL b2b_wr_ack got=%b exp=1", ack); end
    we = 1'b0; dat_i = 16'h0000;
    tick();
    checks++; if (ack !== 1'b0) begin failures++; $display("FAIL b2b_gap_ack got=%b exp=0", ack); end
    tick();
    checks++; if (ack !== 1'b1 || dat_o !== 16'h5A5A) begin failures++; $display("FAIL b2b_rd ack=%b dat=%h exp ack=1 dat=5a5a", ack, dat_o); end
    idle_bus();
    tick();
  endtask

  task automatic test_reset_mid_burst();
    logic a_s, e_s;
    logic [15:0] d;
    cyc = 1'b1; stb = 1'b1; we = 1'b0; b8 = 1'b1; adr = 24'h000000;
    tick();
    tick();
    rst_n = 1'b0;
    tick(); tick();
    checks++; if (ack !== 1'b0 || err !== 1'b0 || rty !== 1'b0 || dat_o !== 16'h0000) begin
      failures++; $display("FAIL rstb_outputs ack=%b err=%b rty=%b dat=%h exp all 0", ack, err, rty, dat_o);
    end
    checks++; if (state !== 2'd0) begin failures++; $display("FAIL rstb_state got=%0d exp=0", state); end
    rst_n = 1'b1;
    idle_bus();
    tick();
    do_read(24'h000010, a_s, e_s, d);
    checks++; if (a_s !== 1'b1 || d !== 16'hA5FF) begin failures++; $display("FAIL rstb_next ack=%b dat=%h exp ack=1 dat=a5ff", a_s, d); end
  endtask

  // ---------------- sequence / report ----------------
  initial begin
    idle_bus();
    test_reset();
    test_fill();
    test_byte_write();
    test_burst4();
    test_burst8_wrap();
    test_burst_abort();
    test_write_burst_err();
    test_addr_err();
    test_back_to_back();
    test_reset_mid_burst();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
